// File: rtl/score_keeper.sv
// Score bookkeeping between the game-object controller and the seven-segment driver:
// saturating BCD/binary score, session high score and a registered segment word.
module score_keeper #(
  parameter int unsigned SCORE_DIV   = 4,
  parameter int unsigned BLINK_TICKS = 32
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        game_clk,
  input  logic [1:0]  game_state,
  input  logic        mode,
  output logic [13:0] score,
  output logic [13:0] high_score,
  output logic        new_record,
  output logic [27:0] display_all
);

  typedef enum logic [1:0] {
    ST_READY = 2'd0,
    ST_RUN   = 2'd1,
    ST_OVER  = 2'd2
  } state_e;

  state_e      state_q, state_d;
  logic        gc_q;
  logic        tick_s;
  logic [7:0]  div_q, div_d;
  logic [7:0]  blink_q, blink_d;
  logic        blank_q, blank_d;
  logic [15:0] bcd_q, bcd_d;
  logic [15:0] hbcd_q, hbcd_d;
  logic [13:0] score_q, score_d;
  logic [13:0] high_q, high_d;
  logic        rec_q, rec_d;
  logic [27:0] disp_q, disp_d;

  function automatic logic [15:0] bcd_inc(input logic [15:0] v);
    logic [15:0] r;
    logic        carry;
    r     = v;
    carry = 1'b1;
    for (int i = 0; i < 4; i++) begin
      if (carry) begin
        if (r[4*i +: 4] == 4'd9) begin
          r[4*i +: 4] = 4'd0;
        end else begin
          r[4*i +: 4] = r[4*i +: 4] + 4'd1;
          carry       = 1'b0;
        end
      end else begin
        carry = 1'b0;
      end
    end
    return r;
  endfunction

  function automatic logic [6:0] seg7(input logic [3:0] d);
    case (d)
      4'd0:    seg7 = 7'h40;
      4'd1:    seg7 = 7'h79;
      4'd2:    seg7 = 7'h24;
      4'd3:    seg7 = 7'h30;
      4'd4:    seg7 = 7'h19;
      4'd5:    seg7 = 7'h12;
      4'd6:    seg7 = 7'h02;
      4'd7:    seg7 = 7'h78;
      4'd8:    seg7 = 7'h00;
      4'd9:    seg7 = 7'h10;
      default: seg7 = 7'h7F;
    endcase
  endfunction

  assign tick_s = game_clk & ~gc_q;

  // Phase FSM, scoring, record compare and blink control.
  always_comb begin
    state_d = state_q;
    div_d   = div_q;
    blink_d = blink_q;
    blank_d = blank_q;
    bcd_d   = bcd_q;
    hbcd_d  = hbcd_q;
    score_d = score_q;
    high_d  = high_q;
    rec_d   = rec_q;
    if (game_state == 2'd0) begin
      state_d = ST_READY;
      div_d   = 8'd0;
      bcd_d   = 16'd0;
      score_d = 14'd0;
      rec_d   = 1'b0;
    end else begin
      case (state_q)
        ST_READY: begin
          if (game_state == 2'd1) state_d = ST_RUN;
          else                    state_d = ST_READY;
        end
        ST_RUN: begin
          if (game_state == 2'd2) begin
            state_d = ST_OVER;
            blink_d = 8'd0;
            blank_d = 1'b0;
            if (score_q > high_q) begin
              high_d = score_q;
              hbcd_d = bcd_q;
              rec_d  = 1'b1;
            end else begin
              rec_d  = 1'b0;
            end
          end else if (game_state == 2'd1 && tick_s) begin
            // Divider wraps even when saturated; only the score holds.
            if (div_q == 8'(SCORE_DIV - 1)) begin
              div_d = 8'd0;
              if (bcd_q != 16'h9999) begin
                bcd_d   = bcd_inc(bcd_q);
                score_d = score_q + 14'd1;
              end else begin
                bcd_d   = bcd_q;
              end
            end else begin
              div_d = div_q + 8'd1;
            end
          end else begin
            state_d = ST_RUN;
          end
        end
        ST_OVER: begin
          if (game_state == 2'd1) begin
            state_d = ST_RUN;
            div_d   = 8'd0;
            bcd_d   = 16'd0;
            score_d = 14'd0;
            rec_d   = 1'b0;
          end else if (game_state == 2'd2 && tick_s) begin
            if (blink_q == 8'(BLINK_TICKS - 1)) begin
              blink_d = 8'd0;
              blank_d = ~blank_q;
            end else begin
              blink_d = blink_q + 8'd1;
            end
          end else begin
            state_d = ST_OVER;
          end
        end
        default: state_d = ST_READY;
      endcase
    end
  end

  // Segment word from the registered digits; blanking applies only to the live score.
  always_comb begin
    disp_d = 28'd0;
    if (!mode && state_q == ST_OVER && blank_q) begin
      disp_d = {4{7'h7F}};
    end else if (mode) begin
      disp_d = {seg7(hbcd_q[15:12]), seg7(hbcd_q[11:8]), seg7(hbcd_q[7:4]), seg7(hbcd_q[3:0])};
    end else begin
      disp_d = {seg7(bcd_q[15:12]), seg7(bcd_q[11:8]), seg7(bcd_q[7:4]), seg7(bcd_q[3:0])};
    end
  end

  // State and datapath registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_READY;
      gc_q    <= 1'b0;
      div_q   <= 8'd0;
      blink_q <= 8'd0;
      blank_q <= 1'b0;
      bcd_q   <= 16'd0;
      hbcd_q  <= 16'd0;
      score_q <= 14'd0;
      high_q  <= 14'd0;
      rec_q   <= 1'b0;
      disp_q  <= {4{7'h40}};
    end else begin
      state_q <= state_d;
      gc_q    <= game_clk;
      div_q   <= div_d;
      blink_q <= blink_d;
      blank_q <= blank_d;
      bcd_q   <= bcd_d;
      hbcd_q  <= hbcd_d;
      score_q <= score_d;
      high_q  <= high_d;
      rec_q   <= rec_d;
      disp_q  <= disp_d;
    end
  end

  assign score       = score_q;
  assign high_score  = high_q;
  assign new_record  = rec_q;
  assign display_all = disp_q;

endmodule
